instr_ptr_rstack: RTL and testbench
===================================

# instr_ptr_rstack

Parametrised instruction pointer with a hardware return-address stack; the next generation of the processor core's `instr_ptr`. It generalises pointer width, reset vector and stack depth, and adds call/return with LIFO return addresses. Sticky overflow and underflow error flags complete the block. It sits between the instruction decoder, which drives jump/call/return strobes, and instruction memory, whose read address is `ptr_out`.

## Interface
- `WIDTH`, 8, pointer and address width in bits.
- `DEPTH`, 4, return-stack entries; must be ≥1.
- `RESET_VAL`, 0, pointer value after reset; must be < 2^WIDTH.
- `DW` (localparam) = clog2(`DEPTH`+1).

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  advance qualifier; 0 = stall, all other controls ignored.
- `load_enable`  in  1  jump: `ptr_out` ← `load_val`.
- `load_val`  in  WIDTH  jump/call target.
- `call`  in  1  push return address `ptr_out`+1, jump to `load_val`.
- `ret`  in  1  pop top of stack into `ptr_out`.
- `clear_err`  in  1  synchronous clear of `overflow`/`underflow`.
- `ptr_out`  out  WIDTH  current instruction pointer, registered.
- `depth_out`  out  DW  number of valid stack entries, 0..`DEPTH`.
- `overflow`  out  1  sticky: a call was made with the stack full.
- `underflow`  out  1  sticky: a ret was made with the stack empty.

## Operation
- Reset (async, any time): `ptr_out`=`RESET_VAL`, `depth_out`=0, `overflow`=0, `underflow`=0. Stack RAM contents are not cleared and are don't-care. Reset dominates every other input.
- With `enable`=1, exactly one action per edge, in priority order ret > call > load_enable > increment:
  - ret, depth>0: `ptr_out` ← stack[depth-1]; depth−1.
  - ret, depth=0: `underflow` ← 1; `ptr_out` ← `ptr_out`+1; depth unchanged.
  - call, depth<DEPTH: stack[depth] ← `ptr_out`+1; depth+1; `ptr_out` ← `load_val`.
  - call, depth=DEPTH: push dropped, `overflow` ← 1; jump still taken (`ptr_out` ← `load_val`); depth stays DEPTH.
  - load_enable: `ptr_out` ← `load_val`; stack untouched.
  - none: `ptr_out` ← `ptr_out`+1.
- `enable`=0: `ptr_out`, stack and depth hold, and call/ret/load are ignored. `clear_err` still acts.
- Simultaneous call and ret: ret wins and call is discarded; no flag is raised for the discarded call.
- Arithmetic: all increments are mod 2^WIDTH. 2^WIDTH−1 wraps to 0. A return address computed at 2^WIDTH−1 is 0.
- `clear_err`=1 clears both flags on the edge. If an error event occurs on the same edge, the set wins.

## Timing
- Single-cycle latency: controls sampled at edge N take effect on `ptr_out`/`depth_out` after edge N.
- Outputs are registered with no combinational path from inputs to outputs.
- Flags assert the edge after the offending call/ret and hold until `clear_err` or reset.
- Reset deassertion: the first edge with `reset`=0 performs the selected action from `RESET_VAL`.

## Test plan
- Increment/wrap (WIDTH=8): release reset with `enable`=1 → `ptr_out` 0,1,2,…; force to 254 via load → next 255 then 0.
- Jump and stall: at `ptr_out`=5 assert `load_enable`, `load_val`=200 → 200, then 201. With `enable`=0 and `load_enable`=1, `load_val`=700 mod 256 → `ptr_out` holds.
- Call/return: at `ptr_out`=10, call with `load_val`=50 → `ptr_out`=50, depth 1. Two increments → 52. Ret → 11, depth 0. Call+ret on the same edge at depth 0 → underflow=1, `ptr_out`+1.
- Overflow/LIFO (DEPTH=4): five nested calls from 10, 20, 30, 40, 50 to targets 20, 30, 40, 50, 60 → depth 4, overflow=1, `ptr_out`=60. Four rets → 41, 31, 21, 11. Fifth ret → underflow=1, `ptr_out`=12.
- Flag clear: `clear_err` pulse → both flags 0. `clear_err` on the same edge as an empty ret → underflow stays 1.
- Async reset mid-call: at depth 2, assert reset between edges → `ptr_out`=`RESET_VAL`, depth 0, flags 0 immediately without waiting for a clock edge.

Source files
------------

// File: rtl/instr_ptr_rstack.sv
// Instruction pointer with a LIFO return-address stack and sticky overflow/underflow flags.
// Latency: one cycle from sampled controls to ptr_out/depth_out. No backpressure: enable=0 stalls the pointer.
module instr_ptr_rstack #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int RESET_VAL = 0,
    localparam int DW       = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             load_enable,
    input  logic [WIDTH-1:0] load_val,
    input  logic             call,
    input  logic             ret,
    input  logic             clear_err,
    output logic [WIDTH-1:0] ptr_out,
    output logic [DW-1:0]    depth_out,
    output logic             overflow,
    output logic             underflow
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] stack [DEPTH];
    logic [WIDTH-1:0] ptr_nxt;
    logic [WIDTH-1:0] ptr_inc;
    logic [DW-1:0]    depth_nxt;
    logic [DW-1:0]    depth_m1;
    logic [AW-1:0]    push_idx;
    logic [AW-1:0]    pop_idx;
    logic             push;
    logic             ovf_set;
    logic             unf_set;
    logic             stack_empty;
    logic             stack_full;

    assign ptr_inc     = ptr_out + WIDTH'(1);
    assign depth_m1    = depth_out - DW'(1);
    assign push_idx    = depth_out[AW-1:0];
    assign pop_idx     = depth_m1[AW-1:0];
    assign stack_empty = (depth_out == '0);
    assign stack_full  = (depth_out == DW'(DEPTH));

    // Priority ret > call > load > increment; a call alongside ret is simply discarded.
    always_comb begin
        ptr_nxt   = ptr_out;
        depth_nxt = depth_out;
        push      = 1'b0;
        ovf_set   = 1'b0;
        unf_set   = 1'b0;
        if (enable) begin
            if (ret) begin
                if (!stack_empty) begin
                    ptr_nxt   = stack[pop_idx];
                    depth_nxt = depth_m1;
                end else begin
                    unf_set = 1'b1;
                    ptr_nxt = ptr_inc;
                end
            end else if (call) begin
                ptr_nxt = load_val;
                if (!stack_full) begin
                    push      = 1'b1;
                    depth_nxt = depth_out + DW'(1);
                end else begin
                    ovf_set = 1'b1;
                end
            end else if (load_enable) begin
                ptr_nxt = load_val;
            end else begin
                ptr_nxt = ptr_inc;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_out   <= WIDTH'(RESET_VAL);
            depth_out <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            ptr_out   <= ptr_nxt;
            depth_out <= depth_nxt;
            // A new error event on the same edge as clear_err keeps the flag set.
            overflow  <= ovf_set | (overflow & ~clear_err);
            underflow <= unf_set | (underflow & ~clear_err);
        end
    end

    // Stack storage is not reset; entries above depth_out are never read.
    always_ff @(posedge clk) begin
        if (push) begin
            stack[push_idx] <= ptr_inc;
        end
    end
endmodule

// File: tb/tb_instr_ptr_rstack.sv
// Bench for instr_ptr_rstack: directed scenarios plus random traffic against a queue-based model.
module tb_instr_ptr_rstack;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int RESET_VAL = 0;
    localparam int MODV = 1 << WIDTH;

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic             load_enable;
    logic [WIDTH-1:0] load_val;
    logic             call;
    logic             ret;
    logic             clear_err;
    logic [WIDTH-1:0] ptr_out;
    logic [2:0]       depth_out;
    logic             overflow;
    logic             underflow;

    int n_checks = 0;
    int n_errors = 0;

    int m_ptr;
    int m_stk[$];
    bit m_ovf;
    bit m_unf;

    instr_ptr_rstack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(RESET_VAL)) dut (
        .clk(clk), .reset(reset), .enable(enable), .load_enable(load_enable),
        .load_val(load_val), .call(call), .ret(ret), .clear_err(clear_err),
        .ptr_out(ptr_out), .depth_out(depth_out), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = RESET_VAL;
        m_stk.delete();
        m_ovf = 0;
        m_unf = 0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".ptr"}, 32'(ptr_out), 32'(m_ptr));
        check({tag, ".depth"}, 32'(depth_out), 32'(m_stk.size()));
        check({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
        check({tag, ".unf"}, 32'(underflow), 32'(m_unf));
    endtask

    task automatic step(input bit en, input bit ld, input int lv, input bit cl,
                        input bit rt, input bit ce, input string tag);
        enable = en; load_enable = ld; load_val = WIDTH'(lv % MODV);
        call = cl; ret = rt; clear_err = ce;
        @(posedge clk);
        if (ce) begin
            m_ovf = 0;
            m_unf = 0;
        end
        if (en) begin
            if (rt) begin
                if (m_stk.size() > 0) m_ptr = m_stk.pop_back();
                else begin m_unf = 1; m_ptr = (m_ptr + 1) % MODV; end
            end else if (cl) begin
                if (m_stk.size() < DEPTH) m_stk.push_back((m_ptr + 1) % MODV);
                else m_ovf = 1;
                m_ptr = lv % MODV;
            end else if (ld) begin
                m_ptr = lv % MODV;
            end else begin
                m_ptr = (m_ptr + 1) % MODV;
            end
        end
        #1;
        check_all(tag);
    endtask

    task automatic inc(input string tag);
        step(1, 0, 0, 0, 0, 0, tag);
    endtask

    initial begin
        reset = 1; enable = 0; load_enable = 0; load_val = '0;
        call = 0; ret = 0; clear_err = 0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        reset = 0;

        // Increment and wrap
        inc("inc1"); inc("inc2"); inc("inc3");
        step(1, 1, 254, 0, 0, 0, "ld254");
        inc("to255");
        inc("wrap0");

        // Jump and stall
        step(1, 1, 5, 0, 0, 0, "ld5");
        step(1, 1, 200, 0, 0, 0, "jmp200");
        inc("inc201");
        step(0, 1, 700, 0, 0, 0, "stall");
        step(0, 0, 0, 1, 1, 0, "stall_cr");

        // Call / return
        step(1, 1, 10, 0, 0, 0, "ld10");
        step(1, 0, 50, 1, 0, 0, "call50");
        inc("c_inc1"); inc("c_inc2");
        step(1, 0, 0, 0, 1, 0, "ret11");
        step(1, 0, 99, 1, 1, 0, "callret_empty");
        step(0, 0, 0, 0, 0, 1, "clr1");

        // Nested calls past capacity, then unwind
        step(1, 1, 10, 0, 0, 0, "ld10b");
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 20 + 10 * i, 1, 0, 0, $sformatf("ncall%0d", i));
            if (i < 4) step(1, 1, 20 + 10 * i, 0, 0, 0, $sformatf("nld%0d", i));
        end
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 1, 0, $sformatf("nret%0d", i));
        step(1, 0, 0, 0, 0, 1, "clr2");
        step(1, 0, 0, 0, 1, 1, "clr_vs_unf");
        step(1, 0, 0, 0, 0, 1, "clr3");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 8) != 0, ($urandom % 4) == 0, int'($urandom % MODV),
                 ($urandom % 4) == 0, ($urandom % 5) == 0, ($urandom % 10) == 0, "rand");
        end

        // Async reset in the middle of a cycle at depth 2
        step(1, 0, 0, 0, 0, 1, "pre_rst_clr");
        step(1, 0, 30, 1, 0, 0, "rcall1");
        step(1, 0, 60, 1, 0, 0, "rcall2");
        while (m_stk.size() < DEPTH) step(1, 0, 77, 1, 0, 0, "rfill");
        step(1, 0, 88, 1, 0, 0, "rovf");
        step(1, 0, 0, 0, 1, 0, "rpop1");
        step(1, 0, 0, 0, 1, 0, "rpop2");
        #1;
        reset = 1;
        model_reset();
        #1;
        check_all("async_rst");
        @(negedge clk);
        reset = 0;
        inc("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
